// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic {OUT_MEALY, OUT_MOORE} out_mode_e;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam logic [7:0]  DEF_PATTERN = 8'b0000_0110;
  localparam int unsigned DEF_LEN     = 3;
  localparam bit          DEF_OVERLAP = 1'b1;

  // Width needed to hold a length in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment leaves the count at one.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q, count_d;

  assign sat   = &count_q;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && !sat) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap / non-overlap detection,
// Mealy or registered output, and a saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          MAX_LEN        = DEF_MAX_LEN,
  parameter int unsigned          CNT_W          = 8,
  parameter bit                   REGISTERED_OUT = 1'b0,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN    = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned          RST_LEN        = DEF_LEN,
  parameter bit                   RST_OVERLAP    = DEF_OVERLAP,
  localparam int unsigned         LEN_W          = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  // A one-bit pattern needs no history; keep a dummy bit so widths stay legal.
  localparam int unsigned     HIST_W   = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;
  localparam out_mode_e       OUT_MODE = REGISTERED_OUT ? OUT_MOORE : OUT_MEALY;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_RST = (RST_LEN > MAX_LEN) ? LEN_MAX : LEN_W'(RST_LEN);

  logic [HIST_W-1:0]  history_q, history_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] cfg_pattern_q, cfg_pattern_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_overlap_q, cfg_overlap_d;

  logic [HIST_W:0]    window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_max;
  logic               pattern_eq;
  logic               match;

  assign window = {history_q, x};

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < cfg_len_q);
    end
  end

  assign fill_max   = (cfg_len_q == '0) ? '0 : cfg_len_q - LEN_W'(1);
  assign pattern_eq = ((window[MAX_LEN-1:0] & len_mask) == (cfg_pattern_q & len_mask));
  assign match      = en && !cfg_load && (cfg_len_q != '0) && (fill_q >= fill_max) && pattern_eq;

  always_comb begin
    history_d     = history_q;
    fill_d        = fill_q;
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    cfg_overlap_d = cfg_overlap_q;
    if (cfg_load) begin
      history_d     = '0;
      fill_d        = '0;
      cfg_pattern_d = pattern;
      cfg_len_d     = (len > LEN_MAX) ? LEN_MAX : len;
      cfg_overlap_d = overlap;
    end else if (en) begin
      history_d = window[HIST_W-1:0];
      if (match) begin
        // Non-overlapping mode demands a full fresh pattern before the next hit.
        fill_d = cfg_overlap_q ? fill_q : '0;
      end else if (fill_q < fill_max) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history_q     <= '0;
      fill_q        <= '0;
      cfg_pattern_q <= RST_PATTERN;
      cfg_len_q     <= LEN_RST;
      cfg_overlap_q <= RST_OVERLAP;
    end else begin
      history_q     <= history_d;
      fill_q        <= fill_d;
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      cfg_overlap_q <= cfg_overlap_d;
    end
  end

  if (OUT_MODE == OUT_MOORE) begin : g_moore
    logic z_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        z_q <= 1'b0;
      end else begin
        z_q <= match;
      end
    end
    assign z = z_q;
  end else begin : g_mealy
    assign z = match;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (clr_cnt),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       x, en, cfg_load, clr_cnt, overlap;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       sx, sen, scfg, sclr, sov;
  logic [7:0] spat;
  logic [3:0] slen;

  logic       z_mealy, sat_mealy, z_moore, sat_moore, z_small, sat_small;
  logic [7:0] cnt_mealy, cnt_moore;
  logic [1:0] cnt_small;

  always #5 clk = ~clk;

  seq_detector_param u_mealy (
    .clk(clk), .rst(rst), .x(x), .en(en), .cfg_load(cfg_load), .pattern(pattern),
    .len(len), .overlap(overlap), .clr_cnt(clr_cnt), .z(z_mealy), .match_cnt(cnt_mealy),
    .cnt_sat(sat_mealy)
  );

  seq_detector_param #(.REGISTERED_OUT(1'b1)) u_moore (
    .clk(clk), .rst(rst), .x(x), .en(en), .cfg_load(cfg_load), .pattern(pattern),
    .len(len), .overlap(overlap), .clr_cnt(clr_cnt), .z(z_moore), .match_cnt(cnt_moore),
    .cnt_sat(sat_moore)
  );

  seq_detector_param #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .x(sx), .en(sen), .cfg_load(scfg), .pattern(spat),
    .len(slen), .overlap(sov), .clr_cnt(sclr), .z(z_small), .match_cnt(cnt_small),
    .cnt_sat(sat_small)
  );

  typedef struct {
    int    sel;
    logic  z;
    int    cnt;
    logic  sat;
    string name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  exp_t me;
  logic maz, masat;
  int   macnt;

  task automatic push_exp(input int sel, input logic ez, input int ecnt, input logic esat,
                          input string nm);
    exp_t e;
    e.sel  = sel;
    e.z    = ez;
    e.cnt  = ecnt;
    e.sat  = esat;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      me = q.pop_front();
      case (me.sel)
        0:       begin maz = z_mealy; macnt = int'(cnt_mealy); masat = sat_mealy; end
        1:       begin maz = z_moore; macnt = int'(cnt_moore); masat = sat_moore; end
        default: begin maz = z_small; macnt = int'(cnt_small); masat = sat_small; end
      endcase
      checks++;
      if (maz !== me.z || macnt != me.cnt || masat !== me.sat) begin
        errors++;
        $display("FAIL %s: got z=%0b cnt=%0d sat=%0b, want z=%0b cnt=%0d sat=%0b",
                 me.name, maz, macnt, masat, me.z, me.cnt, me.sat);
      end
    end
  end

  // Test 1/3 stream; index 10 is an idle cycle to show the Moore pulse has ended.
  logic t1_x  [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic t1_en [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic t1_zm [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic t1_zr [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int   t1_cnt[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2};

  logic t2_x  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic t2_zo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   t2_co [6] = '{0, 0, 0, 0, 1, 1};
  logic t2_zn [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int   t2_cn [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; x = 1'b0; en = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0; overlap = 1'b0;
    pattern = '0; len = '0;
    sx = 1'b0; sen = 1'b0; scfg = 1'b0; sclr = 1'b0; sov = 1'b0; spat = '0; slen = '0;
    push_exp(0, 1'b0, 0, 1'b0, "reset mealy");
    push_exp(1, 1'b0, 0, 1'b0, "reset moore");
    push_exp(2, 1'b0, 0, 1'b0, "reset small");
    tick();
    rst = 1'b1;
    tick();

    // Default 110 on both output styles.
    for (int i = 0; i < 11; i++) begin
      x  = t1_x[i];
      en = t1_en[i];
      push_exp(0, t1_zm[i], t1_cnt[i], 1'b0, $sformatf("t1 mealy bit %0d", i));
      push_exp(1, t1_zr[i], t1_cnt[i], 1'b0, $sformatf("t3 moore bit %0d", i));
      tick();
    end
    en = 1'b0;
    x  = 1'b0;

    // 2-bit counter saturation and clear-with-match.
    sx = 1'b1; sen = 1'b1; scfg = 1'b1; spat = 8'h01; slen = 4'd1; sov = 1'b1;
    push_exp(2, 1'b0, 0, 1'b0, "t4 load");
    tick();
    scfg = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_exp(2, 1'b1, (i < 3) ? i : 3, (i >= 3), $sformatf("t4 hit %0d", i));
      tick();
    end
    sclr = 1'b1;
    push_exp(2, 1'b1, 3, 1'b1, "t4 clr with match");
    tick();
    sclr = 1'b0; sen = 1'b0;
    push_exp(2, 1'b0, 1, 1'b0, "t4 after clr");
    tick();

    // en gating, then cfg_load blocking a completing bit and flushing history.
    en = 1'b1; x = 1'b1;
    push_exp(0, 1'b0, 2, 1'b0, "t5 first 1");
    tick();
    push_exp(0, 1'b0, 2, 1'b0, "t5 second 1");
    tick();
    en = 1'b0; x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1'b0, 2, 1'b0, $sformatf("t5 en low %0d", i));
      tick();
    end
    en = 1'b1;
    push_exp(0, 1'b1, 2, 1'b0, "t5 match after gap");
    tick();
    x = 1'b1;
    push_exp(0, 1'b0, 3, 1'b0, "t5 pre-load 1a");
    tick();
    push_exp(0, 1'b0, 3, 1'b0, "t5 pre-load 1b");
    tick();
    x = 1'b0; cfg_load = 1'b1; pattern = 8'b0000_0110; len = 4'd3; overlap = 1'b1;
    push_exp(0, 1'b0, 3, 1'b0, "t5 load blocks match");
    tick();
    cfg_load = 1'b0;
    push_exp(0, 1'b0, 3, 1'b0, "t5 flushed history");
    tick();
    x = 1'b1;
    push_exp(0, 1'b0, 3, 1'b0, "t5 refill 1a");
    tick();
    push_exp(0, 1'b0, 3, 1'b0, "t5 refill 1b");
    tick();
    x = 1'b0;
    push_exp(0, 1'b1, 3, 1'b0, "t5 rematch");
    tick();

    // 1010 overlapping, then non-overlapping; clr_cnt rides along with each load.
    cfg_load = 1'b1; clr_cnt = 1'b1; pattern = 8'b0000_1010; len = 4'd4; overlap = 1'b1;
    push_exp(0, 1'b0, 4, 1'b0, "t2 load overlap");
    tick();
    cfg_load = 1'b0; clr_cnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = t2_x[i];
      push_exp(0, t2_zo[i], t2_co[i], 1'b0, $sformatf("t2 overlap bit %0d", i));
      tick();
    end
    x = 1'b0; cfg_load = 1'b1; clr_cnt = 1'b1; overlap = 1'b0;
    push_exp(0, 1'b0, 2, 1'b0, "t2 load non-overlap");
    tick();
    cfg_load = 1'b0; clr_cnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = t2_x[i];
      push_exp(0, t2_zn[i], t2_cn[i], 1'b0, $sformatf("t2 non-overlap bit %0d", i));
      tick();
    end
    en = 1'b0;
    push_exp(0, 1'b0, 1, 1'b0, "t2 non-overlap total");
    tick();

    // Asynchronous reset mid-stream restores the default 110 configuration.
    en = 1'b1; x = 1'b1;
    push_exp(0, 1'b0, 1, 1'b0, "t6 pre-reset 1a");
    tick();
    push_exp(0, 1'b0, 1, 1'b0, "t6 pre-reset 1b");
    tick();
    rst = 1'b0; en = 1'b0;
    push_exp(0, 1'b0, 0, 1'b0, "t6 async reset");
    tick();
    rst = 1'b1; en = 1'b1; x = 1'b0;
    push_exp(0, 1'b0, 0, 1'b0, "t6 lone 0");
    tick();
    x = 1'b1;
    push_exp(0, 1'b0, 0, 1'b0, "t6 1a");
    tick();
    push_exp(0, 1'b0, 0, 1'b0, "t6 1b");
    tick();
    x = 1'b0;
    push_exp(0, 1'b1, 0, 1'b0, "t6 default rematch");
    tick();
    en = 1'b0;
    push_exp(0, 1'b0, 1, 1'b0, "t6 count");
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
